rv151_idctl: RTL and testbench

// - Decode-stage controller of the rv151 core: one-entry skid register between fetch and execute.
// - Classifies each instruction's opcode and drives type/instruction to the rv151_imm generator.
// - Enforces valid/ready handshakes on both sides, inserts load-use bubbles and honours redirect flushes.

---
 rtl/rv151_pkg.sv | 31 +++
 rtl/rv151_opdec.sv | 43 ++++
 rtl/rv151_idctl.sv | 132 +++++++++++++
 tb/tb_rv151_idctl.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/rv151_pkg.sv
// rv151 shared decode constants: major opcodes and immediate-format codes.
// Also used by the rv151_imm immediate generator.
package rv151_pkg;

   localparam logic [6:0] OP_LUI   = 7'b0110111;
   localparam logic [6:0] OP_AUIPC = 7'b0010111;
   localparam logic [6:0] OP_JAL   = 7'b1101111;
   localparam logic [6:0] OP_JALR  = 7'b1100111;
   localparam logic [6:0] OP_BR    = 7'b1100011;
   localparam logic [6:0] OP_LD    = 7'b0000011;
   localparam logic [6:0] OP_ST    = 7'b0100011;
   localparam logic [6:0] OP_IMM   = 7'b0010011;
   localparam logic [6:0] OP_REG   = 7'b0110011;
   localparam logic [6:0] OP_SYS   = 7'b1110011;

   typedef enum logic [2:0] {
      IMM_R = 3'd0,
      IMM_I = 3'd1,
      IMM_S = 3'd2,
      IMM_B = 3'd3,
      IMM_U = 3'd4,
      IMM_J = 3'd5
   } imm_tp_e;

   typedef enum logic [1:0] {
      ST_EMPTY = 2'd0,
      ST_FULL  = 2'd1,
      ST_HOLD  = 2'd2
   } idst_e;

endpackage

// File: rtl/rv151_opdec.sv
// rv151 opcode classifier: immediate format, illegal/load flags
// and which source registers the instruction reads.
module rv151_opdec
   import rv151_pkg::*;
(
   input  logic [6:0] i_op,
   output logic [2:0] o_tp,
   output logic       o_ill,
   output logic       o_ld,
   output logic       o_rs1u,
   output logic       o_rs2u
);

   imm_tp_e w_tp;
   logic    w_ill;

   always_comb begin
      w_tp  = IMM_R;
      w_ill = 1'b0;
      unique case (1'b1)
         (i_op == OP_LUI),
         (i_op == OP_AUIPC): w_tp = IMM_U;
         (i_op == OP_JAL):   w_tp = IMM_J;
         (i_op == OP_JALR),
         (i_op == OP_LD),
         (i_op == OP_IMM),
         (i_op == OP_SYS):   w_tp = IMM_I;
         (i_op == OP_ST):    w_tp = IMM_S;
         (i_op == OP_BR):    w_tp = IMM_B;
         (i_op == OP_REG):   w_tp = IMM_R;
         default:            w_ill = 1'b1;
      endcase
   end

   assign o_tp  = w_tp;
   assign o_ill = w_ill;
   assign o_ld  = (i_op == OP_LD);

   assign o_rs1u = (w_tp inside {IMM_R, IMM_I, IMM_S, IMM_B})
                 && !(i_op inside {OP_LUI, OP_AUIPC, OP_JAL});
   assign o_rs2u = w_tp inside {IMM_R, IMM_S, IMM_B};

endmodule

// File: rtl/rv151_idctl.sv
// rv151 decode-stage controller: one-entry skid between fetch and
// execute with load-use bubbles and redirect flush.
module rv151_idctl
   import rv151_pkg::*;
#(
   parameter int LDUSE_BUB = 1,
   parameter bit HAZ_EN    = 1'b1
) (
   input  logic        i_clk,
   input  logic        i_rstn,
   input  logic        i_if_vld,
   output logic        o_if_rdy,
   input  logic [31:0] i_if_ins,
   input  logic [31:0] i_if_pc,
   input  logic        i_flush,
   output logic        o_ex_vld,
   input  logic        i_ex_rdy,
   output logic [31:0] o_ex_ins,
   output logic [31:0] o_ex_pc,
   output logic [2:0]  o_imm_tp,
   output logic        o_ex_ill,
   output logic        o_ex_ld
);

   localparam int AW = $clog2(LDUSE_BUB + 1);

   idst_e          r_state;
   logic [31:0]    r_ins;
   logic [31:0]    r_pc;
   logic [2:0]     r_tp;
   logic           r_ill;
   logic           r_ld;
   logic           r_rs1u;
   logic           r_rs2u;
   logic [AW-1:0]  r_age;
   logic [4:0]     r_ldrd;

   logic [2:0]     w_tp;
   logic           w_ill;
   logic           w_ld;
   logic           w_rs1u;
   logic           w_rs2u;
   logic           w_full;
   logic           w_hit;
   logic           w_haz;
   logic           w_fire;
   logic           w_cap;

   rv151_opdec u_opdec (
      .i_op   (i_if_ins[6:0]),
      .o_tp   (w_tp),
      .o_ill  (w_ill),
      .o_ld   (w_ld),
      .o_rs1u (w_rs1u),
      .o_rs2u (w_rs2u)
   );

   assign w_full = (r_state != ST_EMPTY);
   assign w_hit  = (r_rs1u && (r_ins[19:15] == r_ldrd))
                || (r_rs2u && (r_ins[24:20] == r_ldrd));
   assign w_haz  = HAZ_EN && w_full && (r_age != '0)
                && (r_ldrd != 5'd0) && w_hit;

   assign o_ex_vld = (r_state == ST_FULL) && !w_haz;
   assign w_fire   = o_ex_vld && i_ex_rdy;
   assign o_if_rdy = !i_flush
                  && ((r_state == ST_EMPTY) || w_fire);
   assign w_cap    = i_if_vld && o_if_rdy;

   assign o_ex_ins = r_ins;
   assign o_ex_pc  = r_pc;
   assign o_imm_tp = r_tp;
   assign o_ex_ill = r_ill;
   assign o_ex_ld  = r_ld;

   always_ff @(posedge i_clk) begin
      if (!i_rstn) begin
         r_state <= ST_EMPTY;
         r_ins   <= '0;
         r_pc    <= '0;
         r_tp    <= '0;
         r_ill   <= 1'b0;
         r_ld    <= 1'b0;
         r_rs1u  <= 1'b0;
         r_rs2u  <= 1'b0;
         r_age   <= '0;
         r_ldrd  <= '0;
      end else begin
         if (w_fire && r_ld)
            r_ldrd <= r_ins[11:7];

         if (i_flush || !HAZ_EN)
            r_age <= '0;
         else if (w_fire && r_ld)
            r_age <= AW'(LDUSE_BUB);
         else if (r_age != '0)
            r_age <= r_age - AW'(1);

         if (w_cap) begin
            r_ins  <= i_if_ins;
            r_pc   <= i_if_pc;
            r_tp   <= w_tp;
            r_ill  <= w_ill;
            r_ld   <= w_ld;
            r_rs1u <= w_rs1u;
            r_rs2u <= w_rs2u;
         end

         // HOLD is skipped when the age expires this very edge
         if (i_flush)
            r_state <= ST_EMPTY;
         else begin
            unique case (r_state)
               ST_EMPTY:
                  if (w_cap) r_state <= ST_FULL;
               ST_FULL:
                  if (w_haz) begin
                     if (r_age > AW'(1))
                        r_state <= ST_HOLD;
                  end else if (w_fire && !w_cap)
                     r_state <= ST_EMPTY;
               ST_HOLD:
                  if (r_age <= AW'(1))
                     r_state <= ST_FULL;
               default:
                  r_state <= ST_EMPTY;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_rv151_idctl.sv
// Directed bench for rv151_idctl: reset, streaming, load-use,
// backpressure, flush, illegal opcode and reset during HOLD.
module tb_rv151_idctl;

   localparam int BUB = 3;

   localparam logic [31:0] I_ADDI  = 32'h0050_0093;
   localparam logic [31:0] I_LUI   = 32'h1234_50B7;
   localparam logic [31:0] I_LUI5  = 32'h0002_80B7;
   localparam logic [31:0] I_SW    = 32'h0020_A023;
   localparam logic [31:0] I_BEQ   = 32'h0020_8063;
   localparam logic [31:0] I_JAL   = 32'h0000_006F;
   localparam logic [31:0] I_ADD   = 32'h0020_81B3;
   localparam logic [31:0] I_LW5   = 32'h0000_A283;
   localparam logic [31:0] I_LW0   = 32'h0000_A003;
   localparam logic [31:0] I_DEP1  = 32'h0012_8333;
   localparam logic [31:0] I_DEP2  = 32'h0050_83B3;
   localparam logic [31:0] I_IND   = 32'h0020_8333;
   localparam logic [31:0] I_X0    = 32'h0010_0333;
   localparam logic [31:0] I_ILL   = 32'h0000_007F;

   logic        clk    = 1'b0;
   logic        rstn   = 1'b0;
   logic        if_vld = 1'b0;
   logic        if_rdy;
   logic [31:0] if_ins = '0;
   logic [31:0] if_pc  = '0;
   logic        flush  = 1'b0;
   logic        ex_vld;
   logic        ex_rdy = 1'b0;
   logic [31:0] ex_ins;
   logic [31:0] ex_pc;
   logic [2:0]  imm_tp;
   logic        ex_ill;
   logic        ex_ld;

   int n_pass = 0;
   int n_tot  = 0;

   rv151_idctl #(
      .LDUSE_BUB (BUB),
      .HAZ_EN    (1'b1)
   ) dut (
      .i_clk    (clk),
      .i_rstn   (rstn),
      .i_if_vld (if_vld),
      .o_if_rdy (if_rdy),
      .i_if_ins (if_ins),
      .i_if_pc  (if_pc),
      .i_flush  (flush),
      .o_ex_vld (ex_vld),
      .i_ex_rdy (ex_rdy),
      .o_ex_ins (ex_ins),
      .o_ex_pc  (ex_pc),
      .o_imm_tp (imm_tp),
      .o_ex_ill (ex_ill),
      .o_ex_ld  (ex_ld)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog expired");
      $fatal(1);
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic offer(input logic v,
                        input logic [31:0] ins,
                        input logic [31:0] pc);
      if_vld = v;
      if_ins = ins;
      if_pc  = pc;
   endtask

   task automatic idle();
      if_vld = 1'b0;
      flush  = 1'b0;
      ex_rdy = 1'b1;
      repeat (6) tick();
   endtask

   task automatic test_reset();
      rstn = 1'b0;
      ex_rdy = 1'b0;
      offer(1'b1, I_ADDI, 32'h80);
      tick();
      tick();
      n_tot++; if (ex_vld !== 1'b0) $display("FAIL rst_vld got %b exp 0", ex_vld); else n_pass++;
      n_tot++; if (imm_tp !== 3'd0) $display("FAIL rst_tp got %0d exp 0", imm_tp); else n_pass++;
      n_tot++; if (ex_ins !== 32'h0) $display("FAIL rst_ins got %h exp 0", ex_ins); else n_pass++;
      rstn = 1'b1;
      #1;
      n_tot++; if (if_rdy !== 1'b1) $display("FAIL rst_ifrdy got %b exp 1", if_rdy); else n_pass++;
      tick();
      n_tot++; if (ex_vld !== 1'b1) $display("FAIL cap_vld got %b exp 1", ex_vld); else n_pass++;
      n_tot++; if (imm_tp !== 3'd1) $display("FAIL cap_tp got %0d exp 1", imm_tp); else n_pass++;
      n_tot++; if (ex_ins !== I_ADDI) $display("FAIL cap_ins got %h exp %h", ex_ins, I_ADDI); else n_pass++;
      n_tot++; if (ex_pc !== 32'h80) $display("FAIL cap_pc got %h exp 80", ex_pc); else n_pass++;
   endtask

   task automatic test_stream();
      logic [31:0] ins [5];
      logic [2:0]  tp  [5];
      ins = '{I_LUI, I_SW, I_BEQ, I_JAL, I_ADD};
      tp  = '{3'd4, 3'd2, 3'd3, 3'd5, 3'd0};
      idle();
      for (int i = 0; i < 5; i++) begin
         offer(1'b1, ins[i], 32'h100 + 32'(4 * i));
         #1;
         n_tot++; if (if_rdy !== 1'b1) $display("FAIL str_ifrdy[%0d] got %b exp 1", i, if_rdy); else n_pass++;
         tick();
         n_tot++; if (ex_vld !== 1'b1) $display("FAIL str_vld[%0d] got %b exp 1", i, ex_vld); else n_pass++;
         n_tot++; if (imm_tp !== tp[i]) $display("FAIL str_tp[%0d] got %0d exp %0d", i, imm_tp, tp[i]); else n_pass++;
         n_tot++; if (ex_pc !== 32'h100 + 32'(4 * i)) $display("FAIL str_pc[%0d] got %h", i, ex_pc); else n_pass++;
      end
      if_vld = 1'b0;
      tick();
      n_tot++; if (ex_vld !== 1'b0) $display("FAIL str_drain got %b exp 0", ex_vld); else n_pass++;
   endtask

   task automatic test_loaduse(input logic [31:0] ld,
                               input logic [31:0] dep,
                               input int exp,
                               input string nm);
      int cnt;
      idle();
      offer(1'b1, ld, 32'h300);
      tick();
      n_tot++; if (ex_ld !== 1'b1) $display("FAIL %s_ld got %b exp 1", nm, ex_ld); else n_pass++;
      offer(1'b1, dep, 32'h304);
      #1;
      n_tot++; if (if_rdy !== 1'b1) $display("FAIL %s_ifrdy got %b exp 1", nm, if_rdy); else n_pass++;
      tick();
      if_vld = 1'b0;
      #1;
      cnt = 0;
      while (!ex_vld && cnt < 8) begin
         cnt++;
         tick();
      end
      n_tot++; if (cnt !== exp) $display("FAIL %s_bubbles got %0d exp %0d", nm, cnt, exp); else n_pass++;
      n_tot++; if (ex_ins !== dep) $display("FAIL %s_ins got %h exp %h", nm, ex_ins, dep); else n_pass++;
   endtask

   task automatic test_backpressure();
      idle();
      offer(1'b1, I_ADDI, 32'h200);
      tick();
      ex_rdy = 1'b0;
      offer(1'b1, I_ADD, 32'h204);
      #1;
      for (int i = 0; i < 3; i++) begin
         n_tot++; if (if_rdy !== 1'b0) $display("FAIL bp_ifrdy[%0d] got %b exp 0", i, if_rdy); else n_pass++;
         n_tot++; if (ex_ins !== I_ADDI) $display("FAIL bp_ins[%0d] got %h", i, ex_ins); else n_pass++;
         n_tot++; if (ex_pc !== 32'h200) $display("FAIL bp_pc[%0d] got %h exp 200", i, ex_pc); else n_pass++;
         tick();
      end
      ex_rdy = 1'b1;
      #1;
      n_tot++; if (if_rdy !== 1'b1) $display("FAIL bp_rel_ifrdy got %b exp 1", if_rdy); else n_pass++;
      tick();
      if_vld = 1'b0;
      n_tot++; if (ex_vld !== 1'b1) $display("FAIL bp_rel_vld got %b exp 1", ex_vld); else n_pass++;
      n_tot++; if (ex_pc !== 32'h204) $display("FAIL bp_rel_pc got %h exp 204", ex_pc); else n_pass++;
   endtask

   task automatic test_flush();
      idle();
      offer(1'b1, I_LW5, 32'h300);
      tick();
      offer(1'b1, I_DEP1, 32'h304);
      tick();
      flush = 1'b1;
      offer(1'b1, I_ADDI, 32'h400);
      #1;
      n_tot++; if (if_rdy !== 1'b0) $display("FAIL fl_ifrdy got %b exp 0", if_rdy); else n_pass++;
      tick();
      flush = 1'b0;
      n_tot++; if (ex_vld !== 1'b0) $display("FAIL fl_vld got %b exp 0", ex_vld); else n_pass++;
      offer(1'b1, I_DEP1, 32'h500);
      #1;
      n_tot++; if (if_rdy !== 1'b1) $display("FAIL fl_post_ifrdy got %b exp 1", if_rdy); else n_pass++;
      tick();
      if_vld = 1'b0;
      n_tot++; if (ex_vld !== 1'b1) $display("FAIL fl_dep_vld got %b exp 1", ex_vld); else n_pass++;
      n_tot++; if (ex_pc !== 32'h500) $display("FAIL fl_dep_pc got %h exp 500", ex_pc); else n_pass++;
   endtask

   task automatic test_illegal();
      idle();
      offer(1'b1, I_ILL, 32'h600);
      tick();
      if_vld = 1'b0;
      n_tot++; if (ex_ill !== 1'b1) $display("FAIL ill_flag got %b exp 1", ex_ill); else n_pass++;
      n_tot++; if (imm_tp !== 3'd0) $display("FAIL ill_tp got %0d exp 0", imm_tp); else n_pass++;
      n_tot++; if (ex_ld !== 1'b0) $display("FAIL ill_ld got %b exp 0", ex_ld); else n_pass++;
   endtask

   task automatic test_reset_hold();
      idle();
      offer(1'b1, I_LW5, 32'h700);
      tick();
      offer(1'b1, I_DEP1, 32'h704);
      tick();
      if_vld = 1'b0;
      tick();
      n_tot++; if (ex_vld !== 1'b0) $display("FAIL hold_vld got %b exp 0", ex_vld); else n_pass++;
      n_tot++; if (if_rdy !== 1'b0) $display("FAIL hold_ifrdy got %b exp 0", if_rdy); else n_pass++;
      rstn = 1'b0;
      tick();
      rstn = 1'b1;
      n_tot++; if (ex_vld !== 1'b0) $display("FAIL rh_vld got %b exp 0", ex_vld); else n_pass++;
      n_tot++; if (ex_ins !== 32'h0) $display("FAIL rh_ins got %h exp 0", ex_ins); else n_pass++;
      n_tot++; if (ex_pc !== 32'h0) $display("FAIL rh_pc got %h exp 0", ex_pc); else n_pass++;
      n_tot++; if (imm_tp !== 3'd0) $display("FAIL rh_tp got %0d exp 0", imm_tp); else n_pass++;
      n_tot++; if (ex_ill !== 1'b0) $display("FAIL rh_ill got %b exp 0", ex_ill); else n_pass++;
      n_tot++; if (ex_ld !== 1'b0) $display("FAIL rh_ld got %b exp 0", ex_ld); else n_pass++;
      n_tot++; if (if_rdy !== 1'b1) $display("FAIL rh_ifrdy got %b exp 1", if_rdy); else n_pass++;
      offer(1'b1, I_DEP1, 32'h800);
      tick();
      if_vld = 1'b0;
      n_tot++; if (ex_vld !== 1'b1) $display("FAIL rh_dep_vld got %b exp 1", ex_vld); else n_pass++;
   endtask

   initial begin
      test_reset();
      test_stream();
      test_loaduse(I_LW5, I_DEP1, BUB, "lu_rs1");
      test_loaduse(I_LW5, I_DEP2, BUB, "lu_rs2");
      test_loaduse(I_LW0, I_X0,   0,   "lu_x0");
      test_loaduse(I_LW5, I_IND,  0,   "lu_ind");
      test_loaduse(I_LW5, I_LUI5, 0,   "lu_lui");
      test_backpressure();
      test_flush();
      test_illegal();
      test_reset_hold();
      $display("%0d/%0d checks passed", n_pass, n_tot);
      $finish;
   end

endmodule
